// File: rtl/id_pkg.sv
// +----------------------------------------------------------------------------+
// | id_pkg                                                                     |
// | Opcode/funct encodings, ALU control codes and decode helpers for ID stage. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BGT   = 6'd7;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_SLL = 6'd0;
  localparam logic [5:0] FN_SRL = 6'd2;
  localparam logic [5:0] FN_SRA = 6'd3;
  localparam logic [5:0] FN_MUL = 6'd24;
  localparam logic [5:0] FN_DIV = 6'd26;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_XOR = 6'd38;
  localparam logic [5:0] FN_NOR = 6'd39;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam logic [3:0] ALUCTR_ADD = 4'd0;
  localparam logic [3:0] ALUCTR_SUB = 4'd1;
  localparam logic [3:0] ALUCTR_SLT = 4'd2;
  localparam logic [3:0] ALUCTR_MUL = 4'd3;
  localparam logic [3:0] ALUCTR_DIV = 4'd4;
  localparam logic [3:0] ALUCTR_AND = 4'd5;
  localparam logic [3:0] ALUCTR_OR  = 4'd6;
  localparam logic [3:0] ALUCTR_XOR = 4'd7;
  localparam logic [3:0] ALUCTR_NOR = 4'd8;
  localparam logic [3:0] ALUCTR_SLL = 4'd9;
  localparam logic [3:0] ALUCTR_SRL = 4'd10;
  localparam logic [3:0] ALUCTR_SRA = 4'd11;

  typedef struct packed {
    logic memtoreg;
    logic memwrite;
    logic jump;
    logic beq;
    logic bne;
    logic bgt;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  typedef struct packed {
    logic       legal;
    logic [3:0] aluctr;
  } rfn_t;

  function automatic rfn_t decode_funct(input logic [5:0] funct);
    rfn_t r;
    r.legal  = 1'b1;
    r.aluctr = ALUCTR_ADD;
    case (funct)
      FN_ADD:  r.aluctr = ALUCTR_ADD;
      FN_SUB:  r.aluctr = ALUCTR_SUB;
      FN_SLT:  r.aluctr = ALUCTR_SLT;
      FN_MUL:  r.aluctr = ALUCTR_MUL;
      FN_DIV:  r.aluctr = ALUCTR_DIV;
      FN_AND:  r.aluctr = ALUCTR_AND;
      FN_OR:   r.aluctr = ALUCTR_OR;
      FN_XOR:  r.aluctr = ALUCTR_XOR;
      FN_NOR:  r.aluctr = ALUCTR_NOR;
      FN_SLL:  r.aluctr = ALUCTR_SLL;
      FN_SRL:  r.aluctr = ALUCTR_SRL;
      FN_SRA:  r.aluctr = ALUCTR_SRA;
      default: r.legal  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_bypass.sv
// +----------------------------------------------------------------------------+
// | regfile_bypass                                                             |
// | 2R/1W register file, R0 reads zero, same-cycle write data bypassed to reads.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module regfile_bypass #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RAW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic [RAW-1:0]  ra1_i,
  input  logic [RAW-1:0]  ra2_i,
  input  logic [RAW-1:0]  wa_i,
  input  logic [XLEN-1:0] wd_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o
);

  logic [XLEN-1:0] mem_q [NREG];
  logic            w_we;

  assign w_we = (wa_i != '0);

  // Storage is intentionally not reset; R0 is masked on the read side.
  always_ff @(posedge clk) begin
    if (w_we) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    rd1_o = mem_q[ra1_i];
    if (ra1_i == '0) begin
      rd1_o = '0;
    end else if (w_we && (ra1_i == wa_i)) begin
      rd1_o = wd_i;
    end
  end

  always_comb begin
    rd2_o = mem_q[ra2_i];
    if (ra2_i == '0) begin
      rd2_o = '0;
    end else if (w_we && (ra2_i == wa_i)) begin
      rd2_o = wd_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instruction_decode_hz.sv
// +----------------------------------------------------------------------------+
// | instruction_decode_hz                                                      |
// | ID stage: register read, decode into DX, load-use/stall/flush handling.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module instruction_decode_hz #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RAW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_ir,
  input  logic [XLEN-1:0] if_pc,
  input  logic            ex_stall,
  input  logic            flush,
  input  logic [RAW-1:0]  wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_stall,
  output logic            dx_valid,
  output logic [XLEN-1:0] dx_a,
  output logic [XLEN-1:0] dx_b,
  output logic [XLEN-1:0] dx_rt,
  output logic [RAW-1:0]  dx_rd,
  output logic [3:0]      dx_aluctr,
  output logic            dx_memtoreg,
  output logic            dx_memwrite,
  output logic            dx_jump,
  output logic            dx_beq,
  output logic            dx_bne,
  output logic            dx_bgt,
  output logic [XLEN-1:0] dx_offset,
  output logic [27:0]     dx_address,
  output logic [4:0]      dx_shamt,
  output logic [XLEN-1:0] dx_pc,
  output logic            dx_illegal
);

  import id_pkg::*;

  logic [5:0]      w_op;
  logic [5:0]      w_funct;
  logic [RAW-1:0]  w_rs;
  logic [RAW-1:0]  w_rt;
  logic [RAW-1:0]  w_rdf;
  logic [XLEN-1:0] w_rs_val;
  logic [XLEN-1:0] w_rt_val;
  logic [XLEN-1:0] w_sext;
  rfn_t            w_rfn;

  logic            w_legal;
  logic            w_uses_rt;
  logic            w_use_imm;
  logic [3:0]      w_aluctr;
  ctrl_t           w_ctrl;
  logic [RAW-1:0]  w_dst;
  logic            w_hazard;
  logic            w_issue;
  logic            w_load_data;

  logic            dx_valid_q,   dx_valid_d;
  ctrl_t           dx_ctrl_q,    dx_ctrl_d;
  logic [RAW-1:0]  dx_rd_q,      dx_rd_d;
  logic [3:0]      dx_aluctr_q,  dx_aluctr_d;
  logic            dx_illegal_q, dx_illegal_d;
  logic [XLEN-1:0] dx_a_q,       dx_a_d;
  logic [XLEN-1:0] dx_b_q,       dx_b_d;
  logic [XLEN-1:0] dx_rt_q,      dx_rt_d;
  logic [XLEN-1:0] dx_offset_q,  dx_offset_d;
  logic [27:0]     dx_address_q, dx_address_d;
  logic [4:0]      dx_shamt_q,   dx_shamt_d;
  logic [XLEN-1:0] dx_pc_q,      dx_pc_d;

  assign w_op    = if_ir[31:26];
  assign w_funct = if_ir[5:0];
  assign w_rs    = if_ir[21 +: RAW];
  assign w_rt    = if_ir[16 +: RAW];
  assign w_rdf   = if_ir[11 +: RAW];
  assign w_sext  = {{(XLEN-16){if_ir[15]}}, if_ir[15:0]};
  assign w_rfn   = decode_funct(w_funct);

  regfile_bypass #(
    .XLEN (XLEN),
    .NREG (NREG),
    .RAW  (RAW)
  ) u_regfile (
    .clk   (clk),
    .ra1_i (w_rs),
    .ra2_i (w_rt),
    .wa_i  (wb_rd),
    .wd_i  (wb_data),
    .rd1_o (w_rs_val),
    .rd2_o (w_rt_val)
  );

  always_comb begin
    w_legal   = 1'b0;
    w_uses_rt = 1'b0;
    w_use_imm = 1'b0;
    w_aluctr  = ALUCTR_ADD;
    w_ctrl    = CTRL_NONE;
    w_dst     = '0;
    case (w_op)
      OP_RTYPE: begin
        w_legal   = w_rfn.legal;
        w_uses_rt = 1'b1;
        w_aluctr  = w_rfn.aluctr;
        w_dst     = w_rdf;
      end
      OP_LW: begin
        w_legal         = 1'b1;
        w_use_imm       = 1'b1;
        w_dst           = w_rt;
        w_ctrl.memtoreg = 1'b1;
      end
      OP_SW: begin
        w_legal         = 1'b1;
        w_uses_rt       = 1'b1;
        w_use_imm       = 1'b1;
        w_ctrl.memwrite = 1'b1;
      end
      OP_BEQ: begin
        w_legal    = 1'b1;
        w_uses_rt  = 1'b1;
        w_aluctr   = ALUCTR_SUB;
        w_ctrl.beq = 1'b1;
      end
      OP_BNE: begin
        w_legal    = 1'b1;
        w_uses_rt  = 1'b1;
        w_aluctr   = ALUCTR_SUB;
        w_ctrl.bne = 1'b1;
      end
      OP_BGT: begin
        w_legal    = 1'b1;
        w_uses_rt  = 1'b1;
        w_aluctr   = ALUCTR_SUB;
        w_ctrl.bgt = 1'b1;
      end
      OP_J: begin
        w_legal     = 1'b1;
        w_ctrl.jump = 1'b1;
      end
      OP_ADDI: begin
        w_legal   = 1'b1;
        w_use_imm = 1'b1;
        w_dst     = w_rt;
      end
      default: ;
    endcase
  end

  // A load in DX whose result is needed now must let one bubble through.
  assign w_hazard = dx_valid_q & dx_ctrl_q.memtoreg & (dx_rd_q != '0) & if_valid &
                    ((dx_rd_q == w_rs) | (w_uses_rt & (dx_rd_q == w_rt)));
  assign id_stall    = (ex_stall | w_hazard) & ~flush;
  assign w_issue     = if_valid & ~w_hazard;
  assign w_load_data = flush | ~ex_stall;

  always_comb begin
    dx_valid_d   = dx_valid_q;
    dx_ctrl_d    = dx_ctrl_q;
    dx_rd_d      = dx_rd_q;
    dx_aluctr_d  = dx_aluctr_q;
    dx_illegal_d = 1'b0;
    dx_a_d       = dx_a_q;
    dx_b_d       = dx_b_q;
    dx_rt_d      = dx_rt_q;
    dx_offset_d  = dx_offset_q;
    dx_address_d = dx_address_q;
    dx_shamt_d   = dx_shamt_q;
    dx_pc_d      = dx_pc_q;

    if (w_load_data) begin
      dx_a_d       = w_rs_val;
      dx_b_d       = w_use_imm ? w_sext : w_rt_val;
      dx_rt_d      = w_rt_val;
      dx_offset_d  = {w_sext[XLEN-3:0], 2'b00};
      dx_address_d = {if_ir[25:0], 2'b00};
      dx_shamt_d   = if_ir[10:6];
      dx_pc_d      = if_pc;
    end

    if (flush || !ex_stall) begin
      dx_valid_d  = 1'b0;
      dx_ctrl_d   = CTRL_NONE;
      dx_rd_d     = '0;
      dx_aluctr_d = ALUCTR_ADD;
      if (!flush && w_issue) begin
        if (w_legal) begin
          dx_valid_d  = 1'b1;
          dx_ctrl_d   = w_ctrl;
          dx_rd_d     = w_dst;
          dx_aluctr_d = w_aluctr;
        end else begin
          dx_illegal_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dx_valid_q   <= 1'b0;
      dx_ctrl_q    <= CTRL_NONE;
      dx_rd_q      <= '0;
      dx_aluctr_q  <= '0;
      dx_illegal_q <= 1'b0;
      dx_a_q       <= '0;
      dx_b_q       <= '0;
      dx_rt_q      <= '0;
      dx_offset_q  <= '0;
      dx_address_q <= '0;
      dx_shamt_q   <= '0;
      dx_pc_q      <= '0;
    end else begin
      dx_valid_q   <= dx_valid_d;
      dx_ctrl_q    <= dx_ctrl_d;
      dx_rd_q      <= dx_rd_d;
      dx_aluctr_q  <= dx_aluctr_d;
      dx_illegal_q <= dx_illegal_d;
      dx_a_q       <= dx_a_d;
      dx_b_q       <= dx_b_d;
      dx_rt_q      <= dx_rt_d;
      dx_offset_q  <= dx_offset_d;
      dx_address_q <= dx_address_d;
      dx_shamt_q   <= dx_shamt_d;
      dx_pc_q      <= dx_pc_d;
    end
  end

  assign dx_valid    = dx_valid_q;
  assign dx_a        = dx_a_q;
  assign dx_b        = dx_b_q;
  assign dx_rt       = dx_rt_q;
  assign dx_rd       = dx_rd_q;
  assign dx_aluctr   = dx_aluctr_q;
  assign dx_memtoreg = dx_ctrl_q.memtoreg;
  assign dx_memwrite = dx_ctrl_q.memwrite;
  assign dx_jump     = dx_ctrl_q.jump;
  assign dx_beq      = dx_ctrl_q.beq;
  assign dx_bne      = dx_ctrl_q.bne;
  assign dx_bgt      = dx_ctrl_q.bgt;
  assign dx_offset   = dx_offset_q;
  assign dx_address  = dx_address_q;
  assign dx_shamt    = dx_shamt_q;
  assign dx_pc       = dx_pc_q;
  assign dx_illegal  = dx_illegal_q;

endmodule

`default_nettype wire
